// File: rtl/execution_stage_mc_if.sv
// Bundle of ID/EX inputs, forwarding inputs and EX/MEM outputs of the execute stage.
// master drives the instruction side; slave is the execute stage itself.
interface execution_stage_mc_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned RD_W  = 5
);
    logic             in_valid;
    logic [3:0]       alu_ctrl;
    logic             alu_src;
    logic [WIDTH-1:0] read_data_1;
    logic [WIDTH-1:0] read_data_2;
    logic [WIDTH-1:0] sign_extend_in;
    logic [WIDTH-1:0] ex_mem_fwd;
    logic [WIDTH-1:0] wb_fwd;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic [RD_W-1:0]  rd_in;
    logic             mem_stall;

    logic             stage_stall;
    logic             ex_mem_valid;
    logic [WIDTH-1:0] ex_mem_result;
    logic [WIDTH-1:0] ex_mem_store_data;
    logic [RD_W-1:0]  ex_mem_rd;
    logic [3:0]       ex_mem_nzcv;

    modport master (
        output in_valid, alu_ctrl, alu_src, read_data_1, read_data_2, sign_extend_in,
               ex_mem_fwd, wb_fwd, forward_a, forward_b, rd_in, mem_stall,
        input  stage_stall, ex_mem_valid, ex_mem_result, ex_mem_store_data, ex_mem_rd,
               ex_mem_nzcv
    );

    modport slave (
        input  in_valid, alu_ctrl, alu_src, read_data_1, read_data_2, sign_extend_in,
               ex_mem_fwd, wb_fwd, forward_a, forward_b, rd_in, mem_stall,
        output stage_stall, ex_mem_valid, ex_mem_result, ex_mem_store_data, ex_mem_rd,
               ex_mem_nzcv
    );
endinterface

// File: rtl/execution_stage_mc.sv
// Registered execute stage: forwarding, ALU with NZCV, EX/MEM result register.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier for alu_ctrl 1000.
module execution_stage_mc #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned RD_W  = 5
) (
    input logic                 clk,
    input logic                 reset,
    execution_stage_mc_if.slave ex_if
);
    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOrr   = 4'b0001;
    localparam logic [3:0] OpAdd   = 4'b0010;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpPassB = 4'b0111;
    localparam logic [3:0] OpNor   = 4'b1100;

    function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] reg_val,
                                                 input logic [WIDTH-1:0] ex_val,
                                                 input logic [WIDTH-1:0] wb_val);
        unique case (sel)
            2'b00:   return reg_val;
            2'b10:   return ex_val;
            2'b01:   return wb_val;
            default: return '0;
        endcase
    endfunction

    logic [WIDTH-1:0] op_a, fwd_b, op_b, b_eff, alu_res;
    logic [WIDTH:0]   sum;
    logic             is_sub, alu_c, alu_v, accept, stall, load_alu;
    logic [3:0]       alu_nzcv;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d, store_q, store_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [3:0]       nzcv_q, nzcv_d;

    // Forwarding is resolved before the immediate mux so STUR stores the forwarded value.
    assign op_a  = fwd_mux(ex_if.forward_a, ex_if.read_data_1, ex_if.ex_mem_fwd, ex_if.wb_fwd);
    assign fwd_b = fwd_mux(ex_if.forward_b, ex_if.read_data_2, ex_if.ex_mem_fwd, ex_if.wb_fwd);
    assign op_b  = ex_if.alu_src ? ex_if.sign_extend_in : fwd_b;

    always_comb begin
        is_sub  = (ex_if.alu_ctrl == OpSub);
        b_eff   = is_sub ? ~op_b : op_b;
        sum     = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ex_if.alu_ctrl)
            OpAnd:   alu_res = op_a & op_b;
            OpOrr:   alu_res = op_a | op_b;
            OpAdd, OpSub: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OpPassB: alu_res = op_b;
            OpNor:   alu_res = ~(op_a | op_b);
            default: alu_res = '0;
        endcase
        alu_nzcv = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
    end

`ifdef EXEC_MUL_EN
    localparam logic [3:0]  OpMul = 4'b1000;
    localparam int unsigned CntW  = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, mstore_q, mstore_d;
    logic [RD_W-1:0]  mrd_q, mrd_d;

    assign stall = (state_q != StIdle) || (valid_q && ex_if.mem_stall);
`else
    assign stall = valid_q && ex_if.mem_stall;
`endif
    assign accept = ex_if.in_valid && !stall;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        nzcv_d   = nzcv_q;
        load_alu = 1'b0;
        if (!ex_if.mem_stall) valid_d = 1'b0;
`ifdef EXEC_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        mstore_d = mstore_q;
        mrd_d    = mrd_q;
        unique case (state_q)
            StIdle: begin
                if (accept && ex_if.alu_ctrl == OpMul) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    mstore_d = fwd_b;
                    mrd_d    = ex_if.rd_in;
                    state_d  = StMul;
                end else if (accept) begin
                    load_alu = 1'b1;
                end
            end
            StMul: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StDone;
            end
            StDone: begin
                if (!ex_if.mem_stall) begin
                    valid_d  = 1'b1;
                    result_d = acc_q;
                    store_d  = mstore_q;
                    rd_d     = mrd_q;
                    nzcv_d   = {acc_q[WIDTH-1], acc_q == '0, 2'b00};
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`else
        load_alu = accept;
`endif
        if (load_alu) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            store_d  = fwd_b;
            rd_d     = ex_if.rd_in;
            nzcv_d   = alu_nzcv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            nzcv_q   <= '0;
`ifdef EXEC_MUL_EN
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mstore_q <= '0;
            mrd_q    <= '0;
`endif
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            nzcv_q   <= nzcv_d;
`ifdef EXEC_MUL_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mstore_q <= mstore_d;
            mrd_q    <= mrd_d;
`endif
        end
    end

    assign ex_if.stage_stall       = stall;
    assign ex_if.ex_mem_valid      = valid_q;
    assign ex_if.ex_mem_result     = result_q;
    assign ex_if.ex_mem_store_data = store_q;
    assign ex_if.ex_mem_rd         = rd_q;
    assign ex_if.ex_mem_nzcv       = nzcv_q;
endmodule

// File: doc/execution_stage_mc.md
# execution_stage_mc

Parametrised, registered execute stage for the pipelined ARMv8 core, sitting between the ID/EX and EX/MEM boundaries. It:

- applies operand forwarding to both register operands before immediate selection;
- performs single-cycle ALU operations, or an optional iterative multi-cycle multiply;
- owns the EX/MEM result register, with NZCV flags and a stall handshake toward both neighbours.

## Interface
Parameters:
- WIDTH, 64: datapath width in bits (≥ 8)
- RD_W, 5: destination register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ID/EX holds a valid instruction
- alu_ctrl  in  4  operation: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass B, 1100 NOR, 1000 MUL; others give result 0
- alu_src  in  1  1 selects sign_extend_in as operand B
- read_data_1, read_data_2  in  WIDTH  register file operands
- sign_extend_in  in  WIDTH  immediate
- ex_mem_fwd  in  WIDTH  forward value from EX/MEM
- wb_fwd  in  WIDTH  forward value from MEM/WB
- forward_a, forward_b  in  2  00 register, 10 ex_mem_fwd, 01 wb_fwd, 11 zero
- rd_in  in  RD_W  destination register
- mem_stall  in  1  MEM cannot accept; hold the output register
- stage_stall  out  1  upstream must hold ID/EX contents
- ex_mem_valid  out  1  output register holds a valid result
- ex_mem_result  out  WIDTH  result
- ex_mem_store_data  out  WIDTH  forwarded read_data_2, for STUR
- ex_mem_rd  out  RD_W  destination, passed through
- ex_mem_nzcv  out  4  flags {N,Z,C,V} of the result

## Operation
Operand path:
- op_a = forward_a mux over read_data_1.
- fwd_b = forward_b mux over read_data_2. Forwarding is applied before the immediate mux.
- op_b = alu_src ? sign_extend_in : fwd_b.

Flags:
- ADD/SUB: C is the carry-out of op_a + op_b (SUB computes op_a + ~op_b + 1); V is signed overflow.
- Logic ops, pass B and MUL: C = V = 0.
- N = result[WIDTH-1]; Z = (result == 0).

Acceptance:
- An instruction is accepted when in_valid && !stage_stall.
- stage_stall = (state != IDLE) || (ex_mem_valid && mem_stall).

FSM states:
- IDLE:
  - Accepting a non-MUL op loads the output register and sets ex_mem_valid.
  - Accepting a MUL latches op_a, op_b and rd_in, clears the accumulator and counter, and moves to MUL.
  - No acceptance and !mem_stall: ex_mem_valid clears.
- MUL:
  - Shift-add one multiplier bit per cycle; the counter runs 0..WIDTH-1.
  - After the WIDTH-th iteration, go to DONE.
- DONE:
  - If !mem_stall, load the low WIDTH bits of the product into the output register, set ex_mem_valid, and go to IDLE.
  - Otherwise remain in DONE.

Output register:
- While mem_stall && ex_mem_valid, all ex_mem_* outputs hold their value.
- Overflow of the product beyond WIDTH bits is discarded; no flag reports it.
- Inputs presented while stage_stall is high are ignored; forwarding selects are sampled only at acceptance.

## Timing
- Reset: state IDLE, counter 0, accumulator 0. ex_mem_valid 0, ex_mem_result 0, ex_mem_store_data 0, ex_mem_rd 0, ex_mem_nzcv 0000. stage_stall is therefore 0.
- Single-cycle op accepted at edge N: result visible after edge N (latency 1); throughput 1 per cycle.
- MUL accepted at edge N:
  - stage_stall goes high after N.
  - Iterations run over edges N+1..N+WIDTH.
  - Result loads at edge N+WIDTH+1 if mem_stall is low (latency WIDTH+1, 65 for WIDTH=64).
  - stage_stall drops after that edge.
- mem_stall high in DONE: each stalled cycle adds one cycle of latency. The result is never lost and never duplicated.
- Reset asserted mid-MUL: the operation is abandoned. Outputs return to reset values on that edge and the next accept is honoured the cycle after reset deasserts.
- in_valid with mem_stall high and ex_mem_valid low: accepted; there is no bubble to protect.

## Configuration
- EXEC_MUL_EN defined: MUL implemented as above.
- EXEC_MUL_EN undefined:
  - MUL (1000) behaves as a single-cycle op with result 0 and flags 0100.
  - The MUL/DONE states, accumulator and counter are not built.
  - stage_stall = ex_mem_valid && mem_stall.

## Test plan
- Forwarding:
  - forward_a=10, ex_mem_fwd=5, read_data_1=99, read_data_2=3, ADD → result 8, NZCV 0000.
  - forward_a=11 → result 3.
- Forward-before-immediate: forward_b=01, wb_fwd=0x77, alu_src=1, sign_extend_in=4, read_data_1=1, ADD → result 5, ex_mem_store_data 0x77.
- Flags (WIDTH=64), SUB:
  - 0x8000…0 − 1 → result 0x7FFF…F, NZCV 0011.
  - 7 − 7 → NZCV 0110.
- MUL:
  - 0x1234 × 0x10 → stage_stall high 65 cycles; result 0x12340 appears exactly 65 cycles after acceptance.
  - A second in_valid during busy is not accepted.
- Back-pressure: hold mem_stall during DONE for 3 cycles → outputs frozen and stage_stall high; result delivered once at release. Repeat for a single-cycle ADD result.
- Reset at iteration 20 of a MUL → next cycle state IDLE, ex_mem_valid 0. A following ADD 2+2 → result 4 after 1 cycle.
